tribus_rr_arbiter: RTL and testbench



---
 rtl/tribus_pkg.sv | 33 +++
 rtl/tribus_rr_pick.sv | 32 +++
 rtl/tribus_rr_arbiter.sv | 156 +++++++++++++++
 tb/tb_tribus_rr_arbiter.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/tribus_pkg.sv
// Shared types and helpers for the tri-state bus round-robin arbiter.
// Holds the arbiter state encoding and the wrap-around round-robin pick.
package tribus_pkg;

    localparam int MAX_N    = 16;
    localparam int MAX_TURN = 7;
    localparam int MAX_IDW  = $clog2(MAX_N);

    typedef enum logic [1:0] {ARB_IDLE, ARB_OWN, ARB_TURN} arb_state_t;

    typedef struct packed {
        logic               found;
        logic [MAX_IDW-1:0] idx;
    } pick_t;

    // Bits above the real requester count are zero, so wrapping modulo
    // MAX_N visits the live requesters in the same order as modulo N.
    function automatic pick_t rr_pick(input logic [MAX_N-1:0]   req,
                                      input logic [MAX_IDW-1:0] ptr);
        logic [MAX_N-1:0] rot;
        pick_t            p;
        rot = MAX_N'({req, req} >> ptr);
        p   = '0;
        for (int i = MAX_N - 1; i >= 0; i--) begin
            if (rot[i]) begin
                p.found = 1'b1;
                p.idx   = ptr + MAX_IDW'(i);
            end
        end
        return p;
    endfunction

endpackage

// File: rtl/tribus_rr_pick.sv
// Round-robin winner select: rotate by pointer, priority-encode, unrotate.
// Latency: combinational. Backpressure: none, pure function of req and ptr.
// Requesters at or after ptr win first, wrapping modulo N.
module tribus_rr_pick #(
    parameter  int N   = 4,
    localparam int IDW = $clog2(N)
) (
    input  logic [N-1:0]   req,
    input  logic [IDW-1:0] ptr,
    output logic           found,
    output logic [IDW-1:0] winner
);
    import tribus_pkg::*;

    logic [MAX_N-1:0]   req_ext;
    logic [MAX_IDW-1:0] ptr_ext;
    pick_t              pick;
    logic               unused_idx;

    always_comb begin
        req_ext          = '0;
        req_ext[N-1:0]   = req;
        ptr_ext          = '0;
        ptr_ext[IDW-1:0] = ptr;
    end

    assign pick       = rr_pick(req_ext, ptr_ext);
    assign found      = pick.found;
    assign winner     = pick.idx[IDW-1:0];
    assign unused_idx = ^pick.idx;

endmodule

// File: rtl/tribus_rr_arbiter.sv
// Round-robin owner sequencer for a shared tri/wand/trior net with Z-parked turnaround.
// Latency: req -> grant/oe 1 cycle; TURN_CYCLES parked cycles between owners.
// Backpressure: none; requesters hold req until served. Macro TRIBUS_ARB_LOCK_EN adds lock[].
module tribus_rr_arbiter #(
    parameter  int N           = 4,
    parameter  int MAX_HOLD    = 8,
    parameter  int TURN_CYCLES = 1,
    localparam int IDW         = $clog2(N)
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [N-1:0]   req,
    input  logic [N-1:0]   last,
`ifdef TRIBUS_ARB_LOCK_EN
    input  logic [N-1:0]   lock,
`endif
    output logic [N-1:0]   grant,
    output logic [N-1:0]   oe,
    output logic [IDW-1:0] owner_id,
    output logic           busy,
    output logic           turnaround
);
    import tribus_pkg::*;

    if (N < 2 || N > MAX_N) begin : g_bad_n
        $error("tribus_rr_arbiter: N must be in 2..%0d", MAX_N);
    end
    if (TURN_CYCLES < 1 || TURN_CYCLES > MAX_TURN) begin : g_bad_turn
        $error("tribus_rr_arbiter: TURN_CYCLES must be in 1..%0d", MAX_TURN);
    end
    if (MAX_HOLD < 1 || MAX_HOLD > 255) begin : g_bad_hold
        $error("tribus_rr_arbiter: MAX_HOLD must be in 1..255");
    end

    arb_state_t     state_q, state_d;
    logic [N-1:0]   grant_q, grant_d;
    logic [IDW-1:0] owner_q, owner_d;
    logic [IDW-1:0] ptr_q,   ptr_d;
    logic [7:0]     hold_q,  hold_d;
    logic [2:0]     turn_q,  turn_d;

    logic           found;
    logic [IDW-1:0] winner;
    logic [N-1:0]   win_oh;
    logic           hold_at_max;
    logic           hold_hit;
    logic           release_own;

    tribus_rr_pick #(.N(N)) u_pick (
        .req    (req),
        .ptr    (ptr_q),
        .found  (found),
        .winner (winner)
    );

    always_comb begin
        win_oh         = '0;
        win_oh[winner] = 1'b1;
    end

    assign hold_at_max = (hold_q == 8'(MAX_HOLD));

`ifdef TRIBUS_ARB_LOCK_EN
    // Once lock has carried a grant past MAX_HOLD, the limit stays waived
    // for the rest of that grant; only req drop or last end it.
    logic hold_waived_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_waived_q <= 1'b0;
        end else if (state_q != ARB_OWN) begin
            hold_waived_q <= 1'b0;
        end else if (hold_at_max && lock[owner_q]) begin
            hold_waived_q <= 1'b1;
        end
    end

    assign hold_hit = hold_at_max && !lock[owner_q] && !hold_waived_q;
`else
    assign hold_hit = hold_at_max;
`endif

    assign release_own = !req[owner_q] || last[owner_q] || hold_hit;

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        owner_d = owner_q;
        ptr_d   = ptr_q;
        hold_d  = hold_q;
        turn_d  = turn_q;
        case (state_q)
            ARB_IDLE: begin
                if (found) begin
                    state_d = ARB_OWN;
                    grant_d = win_oh;
                    owner_d = winner;
                    hold_d  = 8'd1;
                end
            end
            ARB_OWN: begin
                if (release_own) begin
                    state_d = ARB_TURN;
                    grant_d = '0;
                    owner_d = '0;
                    ptr_d   = (owner_q == IDW'(N - 1)) ? '0 : owner_q + IDW'(1);
                    hold_d  = '0;
                    turn_d  = 3'd1;
                end else if (!hold_at_max) begin
                    hold_d = hold_q + 8'd1;
                end
            end
            ARB_TURN: begin
                if (turn_q == 3'(TURN_CYCLES)) begin
                    turn_d = '0;
                    if (found) begin
                        state_d = ARB_OWN;
                        grant_d = win_oh;
                        owner_d = winner;
                        hold_d  = 8'd1;
                    end else begin
                        state_d = ARB_IDLE;
                    end
                end else begin
                    turn_d = turn_q + 3'd1;
                end
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ARB_IDLE;
            grant_q <= '0;
            owner_q <= '0;
            ptr_q   <= '0;
            hold_q  <= '0;
            turn_q  <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            owner_q <= owner_d;
            ptr_q   <= ptr_d;
            hold_q  <= hold_d;
            turn_q  <= turn_d;
        end
    end

    assign grant      = grant_q;
    assign oe         = grant_q;
    assign owner_id   = owner_q;
    assign busy       = |grant_q;
    assign turnaround = (state_q == ARB_TURN);

endmodule

// File: tb/tb_tribus_rr_arbiter.sv
// Scoreboard bench for tribus_rr_arbiter: a cycle-level reference model queues expected
// outputs per edge, and a monitor compares them against the DUT after each rising edge.
module tb_tribus_rr_arbiter;

    localparam int N           = 4;
    localparam int MAX_HOLD    = 8;
    localparam int TURN_CYCLES = 1;
    localparam int IDW         = $clog2(N);
`ifdef TRIBUS_ARB_LOCK_EN
    localparam bit LOCK_EN = 1'b1;
`else
    localparam bit LOCK_EN = 1'b0;
`endif

    logic           clk   = 1'b0;
    logic           rst_n = 1'b1;
    logic [N-1:0]   req   = '0;
    logic [N-1:0]   last  = '0;
    logic [N-1:0]   lock  = '0;
    logic [N-1:0]   grant;
    logic [N-1:0]   oe;
    logic [IDW-1:0] owner_id;
    logic           busy;
    logic           turnaround;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    typedef struct {
        logic [N-1:0] grant;
        int           owner;
        logic         turn;
    } exp_t;
    exp_t sb_q[$];

    // Reference model: owner (-1 = none), cycles owned so far, parked cycles left, next-priority index.
    int m_owner = -1;
    int m_held  = 0;
    int m_turn  = 0;
    int m_ptr   = 0;

    tribus_rr_arbiter #(.N(N), .MAX_HOLD(MAX_HOLD), .TURN_CYCLES(TURN_CYCLES)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req        (req),
        .last       (last),
`ifdef TRIBUS_ARB_LOCK_EN
        .lock       (lock),
`endif
        .grant      (grant),
        .oe         (oe),
        .owner_id   (owner_id),
        .busy       (busy),
        .turnaround (turnaround)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
        end
    endtask

    function automatic int pick(input logic [N-1:0] r, input int ptr);
        for (int k = 0; k < N; k++) begin
            if (r[(ptr + k) % N]) return (ptr + k) % N;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_owner = -1;
        m_held  = 0;
        m_turn  = 0;
        m_ptr   = 0;
        sb_q.delete();
    endtask

    // Advance the model across one rising edge with the given inputs and queue the outcome.
    task automatic model_step(input logic [N-1:0] r, input logic [N-1:0] l, input logic [N-1:0] k);
        exp_t e;
        if (m_owner >= 0) begin
            if (!r[m_owner] || l[m_owner] ||
                (m_held == MAX_HOLD && !(LOCK_EN && k[m_owner]))) begin
                m_ptr   = (m_owner + 1) % N;
                m_owner = -1;
                m_turn  = TURN_CYCLES;
            end else begin
                m_held++;
            end
        end else if (m_turn <= 1) begin
            m_turn  = 0;
            m_owner = pick(r, m_ptr);
            m_held  = 1;
        end else begin
            m_turn--;
        end
        e.grant = '0;
        if (m_owner >= 0) e.grant[m_owner] = 1'b1;
        e.owner = m_owner;
        e.turn  = (m_turn > 0);
        sb_q.push_back(e);
    endtask

    task automatic drive(input logic [N-1:0] r, input logic [N-1:0] l, input logic [N-1:0] k);
        @(negedge clk);
        req  = r;
        last = l;
        lock = k;
        cyc++;
        model_step(r, l, k);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #2;
            if (rst_n && sb_q.size() > 0) begin
                e = sb_q.pop_front();
                chk("grant", grant, e.grant);
                chk("oe", oe, e.grant);
                chk("owner_id", owner_id, (e.owner < 0) ? 0 : e.owner);
                chk("turnaround", turnaround, e.turn);
                chk("busy", busy, e.grant != '0);
            end
        end
    end

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        logic [N-1:0] prev;
        logic [N-1:0] r;
        logic [N-1:0] l;
        logic [N-1:0] k;
        int           rises;
        int           last_rise;

        #1 rst_n = 1'b0;
        #2;
        chk("rst_grant", grant, 0);
        chk("rst_oe", oe, 0);
        chk("rst_owner_id", owner_id, 0);
        chk("rst_busy", busy, 0);
        chk("rst_turnaround", turnaround, 0);
        #9 rst_n = 1'b1;

        // Fairness with all requesters active from the reset pointer.
        prev      = '0;
        rises     = 0;
        last_rise = 0;
        for (int i = 0; i < 46; i++) begin
            drive(4'hF, '0, '0);
            if (grant != '0 && prev == '0) begin
                chk("rr_owner", owner_id, rises % N);
                if (rises > 0) chk("rr_spacing", cyc - last_rise, MAX_HOLD + TURN_CYCLES);
                rises++;
                last_rise = cyc;
            end
            prev = grant;
        end
        chk("rr_tenures", rises, 5);

        // Asynchronous reset while requester 0 owns the net.
        drive(4'b0001, '0, '0);
        for (int i = 0; i < 20 && m_owner != 0; i++) drive(4'b0001, '0, '0);
        @(posedge clk);
        #3;
        chk("pre_rst_grant", grant, 4'b0001);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_grant", grant, 0);
        chk("mid_rst_oe", oe, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_owner", owner_id, 0);
        model_reset();
        @(negedge clk);
        #1 rst_n = 1'b1;
        cyc++;
        model_step(4'b0001, '0, '0);
        @(posedge clk);
        #3;
        chk("post_rst_grant", grant, 4'b0001);

        // Early release via last on owner 2's third cycle.
        for (int i = 0; i < TURN_CYCLES + 3; i++) drive('0, '0, '0);
        drive(4'b0100, '0, '0);
        drive(4'b1100, '0, '0);
        drive(4'b1100, '0, '0);
        drive(4'b1100, 4'b0100, '0);
        drive(4'b1000, '0, '0);
        chk("last_turnaround", turnaround, 1);
        chk("last_turn_grant", grant, 0);
        drive(4'b1000, '0, '0);
        chk("last_next_owner", grant, 4'b1000);

        // Owner 3 drops req; wrap to requester 0, then requester 3 alone.
        drive(4'b0001, '0, '0);
        drive(4'b0001, '0, '0);
        drive(4'b0001, '0, '0);
        chk("wrap_grant", grant, 4'b0001);
        drive(4'b1000, '0, '0);
        drive(4'b1000, '0, '0);
        drive(4'b1000, '0, '0);
        chk("only3_grant", grant, 4'b1000);
        drive(4'b1000, 4'b1000, '0);
        drive(4'b1000, '0, '0);
        chk("regrant3_turn", turnaround, 1);
        drive(4'b1000, '0, '0);
        chk("regrant3_grant", grant, 4'b1000);

        // Owner 1 drops req and raises last together; non-owner 0 raises last.
        drive(4'b0010, '0, '0);
        drive(4'b0010, '0, '0);
        drive(4'b0010, '0, '0);
        chk("simul_owner1", grant, 4'b0010);
        drive('0, 4'b0011, '0);
        drive('0, 4'b0001, '0);
        chk("simul_turn", turnaround, 1);
        chk("simul_turn_grant0", grant, 0);
        drive('0, '0, '0);
        chk("simul_idle_turn", turnaround, 0);
        chk("simul_idle_grant", grant, 0);

`ifdef TRIBUS_ARB_LOCK_EN
        // Lock carries owner 0 well past MAX_HOLD; dropping lock alone does not release.
        for (int i = 0; i < 28; i++) drive(4'b0011, '0, 4'b0001);
        chk("lock_held", grant, 4'b0001);
        for (int i = 0; i < 3; i++) drive(4'b0011, '0, '0);
        chk("lock_dropped_held", grant, 4'b0001);
        drive(4'b0011, 4'b0001, '0);
        drive(4'b0011, '0, '0);
        chk("lock_release_turn", turnaround, 1);
`endif

        // Randomized traffic with persistent requests and sporadic last/lock.
        r = req;
        for (int i = 0; i < 1500; i++) begin
            for (int b = 0; b < N; b++) begin
                if ($urandom_range(0, 5) == 0) r[b] = ~r[b];
            end
            l = '0;
            for (int b = 0; b < N; b++) begin
                if ($urandom_range(0, 7) == 0) l[b] = 1'b1;
            end
            k = N'($urandom_range(0, (1 << N) - 1)) & {N{LOCK_EN}};
            drive(r, l, k);
        end

        @(posedge clk);
        #3;
        chk("sb_drained", sb_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
